// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multi-cycle MIPS datapath with ready-handshake memory waits.
module multicycle_control #(
    parameter int TIMEOUT = 0,
    parameter bit EN_BNE  = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] Op_i,
    input  logic       MemReady_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       BranchNe_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       MemToReg_o,
    output logic       RegDst_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic [1:0] PCSrc_o,
    output logic       Error_o,
    output logic [3:0] State_o
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
        ADDIEX = 4'd10, ADDIWB = 4'd11, ERR = 4'd15
    } state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J = 6'b000010;

    state_t state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic waiting, timeout;

    always_comb begin
        waiting = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !MemReady_i;
        timeout = waiting && (TIMEOUT > 0) && (int'(cnt_q) + 1 >= TIMEOUT);
        op_d = (state_q == DECODE) ? Op_i : op_q;
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = timeout ? ERR : (MemReady_i ? DECODE : FETCH);
            DECODE:
                case (Op_i)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_BNE:       state_d = EN_BNE ? BRANCH : ERR;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = ERR;
                endcase
            MEMADR: state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = timeout ? ERR : (MemReady_i ? MEMWB : MEMRD);
            MEMWR:  state_d = timeout ? ERR : (MemReady_i ? FETCH : MEMWR);
            EXEC:   state_d = RWB;
            ADDIEX: state_d = ADDIWB;
            MEMWB, RWB, BRANCH, JUMP, ADDIWB: state_d = FETCH;
            default: state_d = ERR;
        endcase
        // counter only runs while parked in a memory state; saturates at all-ones
        cnt_d = (waiting && state_d == state_q) ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        BranchNe_o    = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemToReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = 2'b00;
        PCSrc_o       = 2'b00;
        case (state_q)
            FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                IRWrite_o = MemReady_i;
                PCWrite_o = MemReady_i;
            end
            DECODE: ALUSrcB_o = 2'b11;
            MEMADR, ADDIEX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
            end
            MEMRD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            MEMWB: begin
                RegWrite_o = 1'b1;
                MemToReg_o = 1'b1;
            end
            MEMWR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
            end
            EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 2'b11;
            end
            RWB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = 2'b01;
                PCWriteCond_o = 1'b1;
                PCSrc_o       = 2'b01;
                BranchNe_o    = (op_q == OP_BNE);
            end
            JUMP: begin
                PCWrite_o = 1'b1;
                PCSrc_o   = 2'b10;
            end
            ADDIWB: RegWrite_o = 1'b1;
            default: ;
        endcase
        // reset is synchronous, so enables must be masked until the reset edge lands
        if (rst_i) begin
            PCWrite_o     = 1'b0;
            PCWriteCond_o = 1'b0;
            MemRead_o     = 1'b0;
            MemWrite_o    = 1'b0;
            IRWrite_o     = 1'b0;
            RegWrite_o    = 1'b0;
        end
    end

    assign Error_o = (state_q == ERR);
    assign State_o = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of three controller configurations (default, bne disabled, TIMEOUT=4).
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic [5:0] op = 6'b000000;
    logic pcw[3], pcwc[3], bne[3], iord[3], mrd[3], mwr[3], irw[3], m2r[3];
    logic rdst[3], rw[3], srca[3], err[3];
    logic [1:0] srcb[3], aluop[3], pcsrc[3];
    logic [3:0] st[3];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_control #(.TIMEOUT(g == 2 ? 4 : 0), .EN_BNE(g != 1)) u_dut (
            .clk_i(clk), .rst_i(rst), .Op_i(op), .MemReady_i(rdy),
            .PCWrite_o(pcw[g]), .PCWriteCond_o(pcwc[g]), .BranchNe_o(bne[g]),
            .IorD_o(iord[g]), .MemRead_o(mrd[g]), .MemWrite_o(mwr[g]),
            .IRWrite_o(irw[g]), .MemToReg_o(m2r[g]), .RegDst_o(rdst[g]),
            .RegWrite_o(rw[g]), .ALUSrcA_o(srca[g]), .ALUSrcB_o(srcb[g]),
            .ALUOp_o(aluop[g]), .PCSrc_o(pcsrc[g]), .Error_o(err[g]), .State_o(st[g])
        );
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ens(input int i);
        return {2'b00, pcw[i], pcwc[i], mrd[i], mwr[i], irw[i], rw[i]};
    endfunction

    initial begin
        // reset with ready high: FETCH enables must still be masked
        tick();
        tick();
        chk("rst_state", st[0], 0);
        chk("rst_enables", ens(0), 0);
        chk("rst_error", err[0], 0);
        rst = 1'b0;
        #1;
        // R-type: 0,1,6,7,0
        chk("r_fetch_irw", irw[0], 1);
        chk("r_fetch_pcw", pcw[0], 1);
        chk("r_fetch_srcb", srcb[0], 2'b01);
        tick();
        chk("r_decode", st[0], 1);
        chk("r_decode_srcb", srcb[0], 2'b11);
        chk("r_decode_rw", rw[0], 0);
        tick();
        chk("r_exec", st[0], 6);
        chk("r_exec_aluop", aluop[0], 2'b11);
        chk("r_exec_rw", rw[0], 0);
        tick();
        chk("r_rwb", st[0], 7);
        chk("r_rwb_rw_rdst", {rw[0], rdst[0], m2r[0]}, 3'b110);
        tick();
        chk("r_back_fetch", st[0], 0);
        // lw with three wait cycles in MEMRD
        op = 6'b100011;
        tick();
        chk("lw_decode", st[0], 1);
        tick();
        chk("lw_memadr", st[0], 2);
        chk("lw_memadr_srcb", srcb[0], 2'b10);
        tick();
        rdy = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("lw_memrd_wait", st[0], 3);
            chk("lw_memrd_ctl", {mrd[0], iord[0], mwr[0]}, 3'b110);
            chk("lw_memrd_t4", st[2], 3);
            tick();
        end
        rdy = 1'b1;
        #1;
        chk("lw_memrd_last", st[0], 3);
        chk("lw_memrd_mwr", mwr[0], 0);
        tick();
        chk("lw_memwb", st[0], 4);
        chk("lw_memwb_ctl", {rw[0], m2r[0], rdst[0], mwr[0]}, 4'b1100);
        chk("lw_t4_no_err", err[2], 0);
        tick();
        chk("lw_done", st[0], 0);
        // bne: branch in default config, ERR when disabled
        op = 6'b000101;
        tick();
        chk("bne_decode", st[0], 1);
        tick();
        chk("bne_branch", st[0], 8);
        chk("bne_branch_ctl", {pcwc[0], bne[0], pcsrc[0], aluop[0]}, 6'b110101);
        chk("bne_dis_err_state", st[1], 15);
        chk("bne_dis_err", err[1], 1);
        tick();
        chk("bne_done", st[0], 0);
        chk("bne_dis_sticky", err[1], 1);
        // beq must not invert the zero test
        op = 6'b000100;
        tick();
        tick();
        chk("beq_branch", st[0], 8);
        chk("beq_bne_flag", bne[0], 0);
        // timeout: four waiting cycles in FETCH
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdy = 1'b0;
        op = 6'b000000;
        tick();
        tick();
        tick();
        chk("to_wait4_state", st[2], 0);
        tick();
        chk("to_err_state", st[2], 15);
        chk("to_err", err[2], 1);
        chk("to_disabled_holds", st[0], 0);
        // ready on the fourth waiting cycle wins over the timeout
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        rdy = 1'b1;
        #1;
        chk("to_race_irw", irw[2], 1);
        tick();
        chk("to_race_decode", st[2], 1);
        chk("to_race_no_err", err[2], 0);
        // illegal opcode: absorbing ERR with all enables low
        op = 6'b111111;
        tick();
        chk("ill_err_state", st[0], 15);
        for (int i = 0; i < 10; i++) begin
            rdy = i[0];
            #1;
            chk("ill_hold_state", st[0], 15);
            chk("ill_hold_enables", ens(0), 0);
            chk("ill_hold_err", err[0], 1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        #1;
        chk("ill_rst_state", st[0], 0);
        chk("ill_rst_err", err[0], 0);
        // reset while a store is waiting in MEMWR
        op = 6'b101011;
        tick();
        tick();
        chk("sw_memadr", st[0], 2);
        tick();
        rdy = 1'b0;
        #1;
        chk("sw_memwr", st[0], 5);
        chk("sw_memwr_ctl", {mwr[0], iord[0], mrd[0]}, 3'b110);
        rst = 1'b1;
        #1;
        chk("sw_rst_mask", mwr[0], 0);
        tick();
        chk("sw_rst_state", st[0], 0);
        chk("sw_rst_mwr", mwr[0], 0);
        rst = 1'b0;
        #1;
        chk("sw_after_mwr", mwr[0], 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-FSM main controller for the multi-cycle MIPS datapath. It supersedes the single-cycle opcode decoder. Each instruction is sequenced over 3–5 states, and each memory access waits on a ready handshake. It drives the shared-ALU, IR, PC and register-file enables and flags illegal opcodes and memory timeouts.

Parameters:
TIMEOUT, 0, max cycles a memory state waits for MemReady_i before entering ERR; 0 disables the timeout
EN_BNE, 1, 1 = opcode 000101 (bne) is decoded; 0 = bne is illegal

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
Op_i  in  6  opcode from IR[31:26]; sampled in DECODE
MemReady_i  in  1  memory access completes this cycle
PCWrite_o  out  1  unconditional PC load
PCWriteCond_o  out  1  PC load qualified by ALU zero
BranchNe_o  out  1  invert zero qualification (bne)
IorD_o  out  1  0 = PC address, 1 = ALUOut address
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
IRWrite_o  out  1  instruction register load
MemToReg_o  out  1  writeback source: 1 = MDR, 0 = ALUOut
RegDst_o  out  1  1 = rd, 0 = rt
RegWrite_o  out  1  register file write
ALUSrcA_o  out  1  0 = PC, 1 = A
ALUSrcB_o  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALUOp_o  out  2  00 add, 01 sub, 11 funct-decoded
PCSrc_o  out  2  00 ALU result, 01 ALUOut, 10 jump target
Error_o  out  1  sticky error
State_o  out  4  current state code, for debug and verification

Behaviour:
- Opcodes: Rtype 000000, addi 001000, lw 100011, sw 101011, beq 000100, bne 000101 (only when EN_BNE = 1), j 000010. Any other opcode is illegal.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, ERR 15.
- All outputs are decoded from the state only (Moore), with one exception: IRWrite_o and PCWrite_o in FETCH are gated by MemReady_i.
- Every output not listed for a state is 0.
- Reset: state = FETCH, wait counter = 0, Error_o = 0.
  - During reset all write/enable outputs are forced to 0.
  - Reset mid-instruction abandons the instruction; no partial write occurs after reset.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSrc = 00.
  - If MemReady_i = 1: IRWrite = 1, PCWrite = 1, next state DECODE.
  - Otherwise hold in FETCH.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target to ALUOut). Next state by Op_i:
  - lw/sw -> MEMADR
  - Rtype -> EXEC
  - beq/bne -> BRANCH
  - j -> JUMP
  - addi -> ADDIEX
  - illegal -> ERR
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state MEMRD (lw) or MEMWR (sw); the opcode is held in an internal register captured in DECODE.
- MEMRD: MemRead = 1, IorD = 1. Waits for MemReady_i, then MEMWB.
- MEMWB: RegWrite = 1, MemToReg = 1, RegDst = 0. Next state FETCH.
- MEMWR: MemWrite = 1, IorD = 1. Waits for MemReady_i, then FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 11. Next state RWB.
- RWB: RegWrite = 1, RegDst = 1, MemToReg = 0. Next state FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSrc = 01, BranchNe = (opcode == bne). Next state FETCH.
- JUMP: PCWrite = 1, PCSrc = 10. Next state FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state ADDIWB.
- ADDIWB: RegWrite = 1, RegDst = 0, MemToReg = 0. Next state FETCH.
- Wait counter:
  - Counts consecutive cycles spent in FETCH/MEMRD/MEMWR with MemReady_i = 0.
  - Clears on any state change and whenever MemReady_i = 1.
  - If TIMEOUT > 0 and the counter reaches TIMEOUT while MemReady_i = 0: next state ERR.
  - If MemReady_i = 1 on that same cycle, the ready completion wins.
  - Counter width is clog2(TIMEOUT+1), minimum 1 bit; it saturates and never wraps.
- ERR: Error_o = 1, all enables 0. ERR is absorbing until rst_i.
- Latencies with zero memory wait:
  - lw: 5 cycles
  - sw, Rtype, addi: 4 cycles
  - beq, bne, j: 3 cycles
  - Each MemReady_i-low cycle adds one cycle.

Test Plan:
- rst_i held 2 cycles, MemReady_i = 1, Op_i = 000000 -> State_o sequence 0,1,6,7,0; RegWrite_o = 1 and RegDst_o = 1 only in the RWB cycle; ALUOp_o = 11 in EXEC.
- lw (100011) with MemReady_i low for 3 cycles in MEMRD, TIMEOUT = 0 -> MEMRD held 4 cycles; MemWrite_o never 1; MEMWB has MemToReg_o = 1; total 8 cycles.
- bne (000101): with EN_BNE = 1 -> BRANCH has PCWriteCond_o = 1, BranchNe_o = 1, PCSrc_o = 01. With EN_BNE = 0 -> DECODE goes to ERR and Error_o = 1 on the next cycle.
- TIMEOUT = 4, MemReady_i = 0 in FETCH -> ERR entered after the 4th waiting cycle. Repeat with MemReady_i rising on the 4th cycle -> DECODE, no error.
- Illegal opcode 111111 -> ERR, held 10 cycles with all enables 0; rst_i pulse -> FETCH, Error_o = 0.
- rst_i asserted in MEMWR -> no MemWrite_o after the reset edge; State_o = 0 next cycle.
